// File: rtl/secret_accum_pipe.sv
// NUM_CH independent unsigned accumulators (wrap/saturate, sticky overflow, sample counter)
// alongside a LAT-deep registered pass-through of {valid, data}.
module secret_accum_pipe #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 32,
    parameter int ACC_W  = 40,
    parameter int DATA_W = 129,
    parameter int LAT    = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [NUM_CH*IN_W-1:0]   in_data,
    input  logic                     clr,
    input  logic                     sat_mode,
    output logic [NUM_CH*ACC_W-1:0]  accum_out,
    output logic [NUM_CH-1:0]        ovf,
    output logic [CNT_W-1:0]         sample_cnt,
    input  logic                     pass_valid_in,
    input  logic [DATA_W-1:0]        pass_in,
    output logic                     pass_valid_out,
    output logic [DATA_W-1:0]        pass_out
);

    localparam int ZEXT_W = ACC_W + 1 - IN_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] pipe_data_r [LAT];
    logic [LAT-1:0]    pipe_valid_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACC_W-1:0] acc_r;
        logic             ovf_r;
        logic [ACC_W-1:0] base_s;
        logic [ACC_W:0]   sum_s;
        logic [ACC_W-1:0] acc_nxt_s;
        logic             ovf_nxt_s;

        // Next-state for one channel: clear first, then add with carry-out detection.
        always_comb begin
            base_s    = clr ? {ACC_W{1'b0}} : acc_r;
            sum_s     = {1'b0, base_s} + {{ZEXT_W{1'b0}}, in_data[c*IN_W +: IN_W]};
            acc_nxt_s = base_s;
            ovf_nxt_s = clr ? 1'b0 : ovf_r;
            if (in_valid) begin
                if (sum_s[ACC_W]) begin
                    acc_nxt_s = sat_mode ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
                    ovf_nxt_s = 1'b1;
                end else begin
                    acc_nxt_s = sum_s[ACC_W-1:0];
                end
            end else begin
                acc_nxt_s = base_s;
            end
        end

        // Channel accumulator and sticky overflow registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_r <= {ACC_W{1'b0}};
                ovf_r <= 1'b0;
            end else begin
                acc_r <= acc_nxt_s;
                ovf_r <= ovf_nxt_s;
            end
        end

        assign accum_out[c*ACC_W +: ACC_W] = acc_r;
        assign ovf[c]                      = ovf_r;
    end

    // Accepted-sample counter; clear-then-add yields a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= in_valid ? CNT_ONE : {CNT_W{1'b0}};
        end else if (in_valid) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Free-running pass-through shift register; data moves regardless of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_data_r[i]  <= {DATA_W{1'b0}};
                pipe_valid_r[i] <= 1'b0;
            end
        end else begin
            pipe_data_r[0]  <= pass_in;
            pipe_valid_r[0] <= pass_valid_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_data_r[i]  <= pipe_data_r[i-1];
                pipe_valid_r[i] <= pipe_valid_r[i-1];
            end
        end
    end

    assign sample_cnt     = cnt_r;
    assign pass_out       = pipe_data_r[LAT-1];
    assign pass_valid_out = pipe_valid_r[LAT-1];

endmodule

// File: doc/secret_accum_pipe.md
Name: secret_accum_pipe

Overview:
- Parametrised successor to the single-channel secret accumulator used in protected-library DPI tests.
- Provides NUM_CH independent unsigned accumulators with wrap or saturate mode, sticky per-channel overflow, synchronous clear, and a sample counter.
- Adds a LAT-stage registered pass-through of arbitrary width with a valid bit, so the protect-lib wrapper is exercised with wide, multi-cycle, reset-sensitive state.

Parameters:
- NUM_CH, 4, number of accumulator channels (>=1).
- IN_W, 32, per-channel input width (>=1).
- ACC_W, 40, per-channel accumulator width (>=IN_W).
- DATA_W, 129, pass-through data width (>=1; covers the >64-bit case).
- LAT, 2, pass-through pipeline depth in cycles (>=1).
- CNT_W, 16, sample counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is summed this cycle.
- in_data  input  NUM_CH*IN_W  channel c at bits [c*IN_W +: IN_W], unsigned.
- clr  input  1  synchronous clear of accumulators, ovf and sample_cnt.
- sat_mode  input  1  0 = wrap, 1 = saturate; sampled every cycle.
- accum_out  output  NUM_CH*ACC_W  registered accumulator values, channel c at [c*ACC_W +: ACC_W].
- ovf  output  NUM_CH  sticky per-channel overflow flag.
- sample_cnt  output  CNT_W  count of accepted in_valid cycles; wraps.
- pass_valid_in  input  1  pass_in qualifier.
- pass_in  input  DATA_W  pass-through data.
- pass_valid_out  output  1  pass_valid_in delayed LAT cycles.
- pass_out  output  DATA_W  pass_in delayed LAT cycles.

Behaviour:
- Reset (rst_n low, asynchronous): all accumulators, ovf, sample_cnt, all pipeline data and valid stages are 0.
- Outputs are 0 while rst_n is low. After deassertion, the first clk edge operates normally.
- Accumulate: on a clk edge with in_valid=1 and clr=0, for each channel c:
  - Compute sum = acc[c] + zero-extended in_data[c] at ACC_W+1 bits.
  - If the carry bit is set: wrap mode keeps acc[c] = sum[ACC_W-1:0]; saturate mode sets acc[c] = all ones. In both modes ovf[c] is set to 1.
  - Otherwise acc[c] = sum[ACC_W-1:0].
  - An accumulator already at all ones in saturate mode stays there. A nonzero input in that state sets ovf again (no change, flag already set).
- in_valid=0: accumulators hold.
- Channels are independent: overflow on one channel never affects another.
- sample_cnt increments by 1 on every in_valid=1 edge, wrapping from 2^CNT_W-1 to 0 silently (no flag).
- clr=1 with in_valid=0: acc = 0, ovf = 0, sample_cnt = 0.
- clr=1 with in_valid=1 (clear-then-add): acc[c] = zero-extended in_data[c], ovf = 0, sample_cnt = 1.
- sat_mode may change at any cycle. It affects only the current cycle's overflow handling and never alters stored values retroactively.
- Accumulate latency: accum_out reflects an input on the edge that samples it (1 cycle, registered output).
- Pass-through: LAT-deep shift register of {valid, data}, advancing every cycle with no stall.
  - pass_out = pass_in from exactly LAT edges earlier.
  - Data stages shift even when valid=0, so pass_out follows pass_in irrespective of valid.
- Mid-operation reset: all in-flight pipeline entries are discarded (valid=0, data=0). Accumulators and counter return to 0 immediately, without waiting for clk.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: all outputs 0. Apply in_valid=1 with ch0=5, ch1=7 for 3 cycles → accum ch0=15, ch1=21, sample_cnt=3, ovf=0.
- Wrap mode, ACC_W=40: preload ch2 to 2^40-2, add 5 → acc ch2=3, ovf[2]=1, other ovf bits 0. Then clr → all 0.
- Saturate mode: ch3 at 2^40-2, add 5 → acc ch3=2^40-1, ovf[3]=1. Add 1 more → stays 2^40-1. Switch to wrap and add 1 → 0.
- clr and in_valid together, ch0=9 → ch0=9, ovf=0, sample_cnt=1. clr alone → all 0.
- Pass-through, LAT=2, DATA_W=129: drive pass_in = {1'b1, 128'h0123...cdef} with valid for 1 cycle → it appears exactly 2 edges later with pass_valid_out=1 for one cycle. The bit-128 MSB is preserved.
- Assert rst_n low asynchronously between edges, with a valid entry in stage 1 and nonzero accumulators → outputs are 0 before the next edge. After release, pass_valid_out stays 0 for LAT cycles.
